pc_fetch_unit: RTL and testbench

- Instruction fetch stage of the memory-to-memory vector processor.
- Owns the architectural fetch PC and issues single-outstanding word reads to instruction memory.
- Buffers returned instructions with their PCs and hands them to decode over a valid/ready handshake.
- Sits directly downstream of the PC adder: the adder's +1 and branch-target results become this block's next PC; branch redirects from execute flush it.

---
 rtl/pc_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word reads and
// buffers returned instructions for decode. Define FETCH_BUF2_EN for a two-entry buffer.
`timescale 1ns / 1ps

module pc_fetch_unit #(
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       DATA_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    // Instruction memory
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    // Redirect from execute
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    // Decode handshake
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_instr,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready
);

`ifdef FETCH_BUF2_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrop
    } state_e;

    state_e            state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [1:0]        count_q;

    logic push;
    logic pop;
    logic has_space;

    // A redirect overrides both push and pop in the same cycle.
    assign pop       = (count_q != 2'd0) && ir_ready;
    assign push      = (state_q == StReq) && imem_ack && !br_taken;
    // Space is reserved before issuing, so a returned word always has a slot.
    assign has_space = (count_q - {1'b0, pop}) < DEPTH;

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ir_valid  = (count_q != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            addr_q  <= RESET_VECTOR;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!br_taken && has_space) begin
                        state_q <= StReq;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                StReq: begin
                    if (imem_ack) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end else if (br_taken) begin
                        // Memory still owes a response at the old address; swallow it.
                        state_q <= StDrop;
                    end
                end
                StDrop: begin
                    if (imem_ack) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_VECTOR;
        end else if (br_taken) begin
            fetch_pc_q <= br_target;
        end else if (push) begin
            fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
        end else if (br_taken) begin
            count_q <= 2'd0;
        end else if (push && !pop) begin
            count_q <= count_q + 2'd1;
        end else if (pop && !push) begin
            count_q <= count_q - 2'd1;
        end
    end

`ifdef FETCH_BUF2_EN
    logic [ADDR_W-1:0] pc_buf_q    [2];
    logic [DATA_W-1:0] instr_buf_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_buf_q    <= '{default: '0};
            instr_buf_q <= '{default: '0};
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
        end else if (br_taken) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                pc_buf_q[wr_ptr_q]    <= addr_q;
                instr_buf_q[wr_ptr_q] <= imem_rdata;
                wr_ptr_q              <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
        end
    end

    assign ir_pc    = pc_buf_q[rd_ptr_q];
    assign ir_instr = instr_buf_q[rd_ptr_q];
`else
    logic [ADDR_W-1:0] pc_buf_q;
    logic [DATA_W-1:0] instr_buf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_buf_q    <= '0;
            instr_buf_q <= '0;
        end else if (push) begin
            pc_buf_q    <= addr_q;
            instr_buf_q <= imem_rdata;
        end
    end

    assign ir_pc    = pc_buf_q;
    assign ir_instr = instr_buf_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit; memory returns addr + 0x1000 unless a test overrides it.
`timescale 1ns / 1ps

module tb_pc_fetch_unit;

`ifdef FETCH_BUF2_EN
    localparam int unsigned STALL_REQS     = 2;
    localparam logic [15:0] FILL_NEXT_ADDR = 16'h0012;
`else
    localparam int unsigned STALL_REQS     = 1;
    localparam logic [15:0] FILL_NEXT_ADDR = 16'h0011;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        br_taken;
    logic [15:0] br_target;
    logic        ir_valid;
    logic [15:0] ir_instr;
    logic [15:0] ir_pc;
    logic        ir_ready;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .RESET_VECTOR(16'h0010)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .br_taken  (br_taken),
        .br_target (br_target),
        .ir_valid  (ir_valid),
        .ir_instr  (ir_instr),
        .ir_pc     (ir_pc),
        .ir_ready  (ir_ready)
    );

    // Zero-wait memory response for the next rising edge.
    task automatic mem_step();
        imem_ack   = imem_req;
        imem_rdata = imem_req ? imem_addr + 16'h1000 : 16'h0000;
    endtask

    task automatic apply_reset();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        br_taken   = 1'b0;
        br_target  = 16'h0000;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        ir_ready   = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        br_taken   = 1'b0;
        br_target  = 16'h0000;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b0) $display("FAIL reset_req: got %b, expected 0", imem_req);
        else passes++;
        total++;
        if (ir_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", ir_valid);
        else passes++;
        total++;
        if (ir_instr !== 16'h0000) $display("FAIL reset_instr: got %h, expected 0000", ir_instr);
        else passes++;
        total++;
        if (ir_pc !== 16'h0000) $display("FAIL reset_pc: got %h, expected 0000", ir_pc);
        else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1) $display("FAIL first_req: got %b, expected 1", imem_req);
        else passes++;
        total++;
        if (imem_addr !== 16'h0010) $display("FAIL first_addr: got %h, expected 0010", imem_addr);
        else passes++;
    endtask

    task automatic test_stream();
        logic [15:0] exp_a [3];
        logic [15:0] exp_d [3];
        int hs;
        int pops;
        exp_a = '{16'h0010, 16'h0011, 16'h0012};
        exp_d = '{16'h1010, 16'h1011, 16'h1012};
        hs    = 0;
        pops  = 0;
        apply_reset();
        ir_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (imem_req && hs < 3) begin
                total++;
                if (imem_addr !== exp_a[hs])
                    $display("FAIL stream_addr%0d: got %h, expected %h", hs, imem_addr, exp_a[hs]);
                else passes++;
                total++;
                if (i != 1 + 2 * hs)
                    $display("FAIL stream_cadence%0d: got cycle %0d, expected %0d", hs, i, 1 + 2 * hs);
                else passes++;
                hs++;
            end
            if (ir_valid && pops < 3) begin
                total++;
                if (ir_pc !== exp_a[pops])
                    $display("FAIL stream_pc%0d: got %h, expected %h", pops, ir_pc, exp_a[pops]);
                else passes++;
                total++;
                if (ir_instr !== exp_d[pops])
                    $display("FAIL stream_instr%0d: got %h, expected %h", pops, ir_instr, exp_d[pops]);
                else passes++;
                pops++;
            end
            mem_step();
            @(negedge clk);
        end
        total++;
        if (hs != 3 || pops != 3)
            $display("FAIL stream_counts: got %0d req %0d pop, expected 3 and 3", hs, pops);
        else passes++;
    endtask

    task automatic test_stall();
        logic [15:0] exp_a [3];
        logic [15:0] exp_d [3];
        int hs;
        int pops;
        exp_a = '{16'h0010, 16'h0011, 16'h0012};
        exp_d = '{16'h1010, 16'h1011, 16'h1012};
        hs    = 0;
        pops  = 0;
        apply_reset();
        ir_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (imem_req) begin
                if (hs < 3) begin
                    total++;
                    if (imem_addr !== exp_a[hs])
                        $display("FAIL stall_addr%0d: got %h, expected %h", hs, imem_addr, exp_a[hs]);
                    else passes++;
                end
                hs++;
            end
            mem_step();
            @(negedge clk);
        end
        total++;
        if (hs != int'(STALL_REQS))
            $display("FAIL stall_req_count: got %0d, expected %0d", hs, STALL_REQS);
        else passes++;
        total++;
        if (imem_req !== 1'b0) $display("FAIL stall_req_low: got %b, expected 0", imem_req);
        else passes++;
        total++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0010)
            $display("FAIL stall_head: got valid %b pc %h, expected 1 0010", ir_valid, ir_pc);
        else passes++;
        ir_ready = 1'b1;
        for (int i = 0; i < 12 && pops < 3; i++) begin
            if (ir_valid) begin
                total++;
                if (ir_pc !== exp_a[pops])
                    $display("FAIL drain_pc%0d: got %h, expected %h", pops, ir_pc, exp_a[pops]);
                else passes++;
                total++;
                if (ir_instr !== exp_d[pops])
                    $display("FAIL drain_instr%0d: got %h, expected %h", pops, ir_instr, exp_d[pops]);
                else passes++;
                pops++;
            end
            if (imem_req) begin
                if (hs < 3) begin
                    total++;
                    if (imem_addr !== exp_a[hs])
                        $display("FAIL drain_addr%0d: got %h, expected %h", hs, imem_addr, exp_a[hs]);
                    else passes++;
                end
                hs++;
            end
            mem_step();
            @(negedge clk);
        end
        total++;
        if (pops != 3 || hs != 3)
            $display("FAIL drain_counts: got %0d pop %0d req, expected 3 and 3", pops, hs);
        else passes++;
    endtask

    task automatic test_drop();
        apply_reset();
        ir_ready = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0010)
            $display("FAIL drop_req0: got %b %h, expected 1 0010", imem_req, imem_addr);
        else passes++;
        br_taken  = 1'b1;
        br_target = 16'h0100;
        @(negedge clk);
        br_taken = 1'b0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0010)
            $display("FAIL drop_hold1: got %b %h, expected 1 0010", imem_req, imem_addr);
        else passes++;
        total++;
        if (ir_valid !== 1'b0) $display("FAIL drop_valid1: got %b, expected 0", ir_valid);
        else passes++;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0010)
            $display("FAIL drop_hold2: got %b %h, expected 1 0010", imem_req, imem_addr);
        else passes++;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0010)
            $display("FAIL drop_hold3: got %b %h, expected 1 0010", imem_req, imem_addr);
        else passes++;
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
        @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (imem_req !== 1'b0 || ir_valid !== 1'b0)
            $display("FAIL drop_after_ack: got req %b valid %b, expected 0 0", imem_req, ir_valid);
        else passes++;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0100 || ir_valid !== 1'b0)
            $display("FAIL drop_target_req: got %b %h valid %b, expected 1 0100 0",
                     imem_req, imem_addr, ir_valid);
        else passes++;
        imem_ack   = 1'b1;
        imem_rdata = 16'h1100;
        @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0100 || ir_instr !== 16'h1100)
            $display("FAIL drop_target_data: got %b %h %h, expected 1 0100 1100",
                     ir_valid, ir_pc, ir_instr);
        else passes++;
    endtask

    task automatic test_br_ack();
        apply_reset();
        ir_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mem_step();
            @(negedge clk);
        end
        imem_ack = 1'b0;
        ir_ready = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== FILL_NEXT_ADDR)
            $display("FAIL brack_req: got %b %h, expected 1 %h", imem_req, imem_addr, FILL_NEXT_ADDR);
        else passes++;
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        br_taken   = 1'b1;
        br_target  = 16'h0200;
        @(negedge clk);
        imem_ack = 1'b0;
        br_taken = 1'b0;
        total++;
        if (ir_valid !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL brack_flush: got valid %b req %b, expected 0 0", ir_valid, imem_req);
        else passes++;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0200 || ir_valid !== 1'b0)
            $display("FAIL brack_target_req: got %b %h valid %b, expected 1 0200 0",
                     imem_req, imem_addr, ir_valid);
        else passes++;
        imem_ack   = 1'b1;
        imem_rdata = 16'h1200;
        @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0200 || ir_instr !== 16'h1200)
            $display("FAIL brack_target_data: got %b %h %h, expected 1 0200 1200",
                     ir_valid, ir_pc, ir_instr);
        else passes++;
    endtask

    task automatic test_wrap();
        apply_reset();
        ir_ready  = 1'b1;
        br_taken  = 1'b1;
        br_target = 16'hFFFF;
        @(negedge clk);
        br_taken = 1'b0;
        total++;
        if (imem_req !== 1'b0) $display("FAIL wrap_gap: got %b, expected 0", imem_req);
        else passes++;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF)
            $display("FAIL wrap_req0: got %b %h, expected 1 ffff", imem_req, imem_addr);
        else passes++;
        imem_ack   = 1'b1;
        imem_rdata = 16'h0FFF;
        @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'hFFFF || ir_instr !== 16'h0FFF)
            $display("FAIL wrap_data0: got %b %h %h, expected 1 ffff 0fff", ir_valid, ir_pc, ir_instr);
        else passes++;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
            $display("FAIL wrap_req1: got %b %h, expected 1 0000", imem_req, imem_addr);
        else passes++;
        imem_ack   = 1'b1;
        imem_rdata = 16'h1000;
        @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0000 || ir_instr !== 16'h1000)
            $display("FAIL wrap_data1: got %b %h %h, expected 1 0000 1000", ir_valid, ir_pc, ir_instr);
        else passes++;
    endtask

    task automatic test_reset_in_drop();
        apply_reset();
        ir_ready = 1'b1;
        @(negedge clk);
        br_taken  = 1'b1;
        br_target = 16'h0300;
        @(negedge clk);
        br_taken = 1'b0;
        total++;
        if (imem_req !== 1'b1) $display("FAIL rstdrop_in_drop: got %b, expected 1", imem_req);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || ir_valid !== 1'b0)
            $display("FAIL rstdrop_async: got req %b valid %b, expected 0 0", imem_req, ir_valid);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0010)
            $display("FAIL rstdrop_restart: got %b %h, expected 1 0010", imem_req, imem_addr);
        else passes++;
        imem_ack   = 1'b1;
        imem_rdata = 16'h1010;
        @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0010 || ir_instr !== 16'h1010)
            $display("FAIL rstdrop_data: got %b %h %h, expected 1 0010 1010", ir_valid, ir_pc, ir_instr);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_drop();
        test_br_ack();
        test_wrap();
        test_reset_in_drop();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
